// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters and writes each result back
// through a single register-file port: low half to rd, high half to rd+1 for MUL/SH.
module alu_arbiter #(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [2:0]            req0_op,
    input  logic [15:0]           req0_s0,
    input  logic [15:0]           req0_s1,
    input  logic [REG_ADDR_W-1:0] req0_rd,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [2:0]            req1_op,
    input  logic [15:0]           req1_s0,
    input  logic [15:0]           req1_s1,
    input  logic [REG_ADDR_W-1:0] req1_rd,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [15:0]           wb_data,
    output logic                  done0,
    output logic                  done1,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } state_t;

    state_t state, state_next;

    logic                  last_grant;
    logic                  grant_id;
    logic [2:0]            op_q;
    logic [15:0]           s0_q;
    logic [15:0]           s1_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [REG_ADDR_W-1:0] rd_hi;
    logic [15:0]           lo_q;
    logic [15:0]           hi_q;
    logic                  write_high_q;

    logic                  pick1;
    logic                  accept;
    logic [31:0]           alu_result;
    logic                  alu_write_high;
    logic [31:0]           mul_a;
    logic [31:0]           mul_b;

    // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
    always_comb begin
        pick1      = req1_valid & (~req0_valid | ~last_grant);
        accept     = rst_n & (state == IDLE) & (req0_valid | req1_valid);
        req0_ready = accept & ~pick1;
        req1_ready = accept & pick1;
    end

    // Sign-extending both operands to 32 bits lets the low half of a plain
    // multiply carry the full signed 16x16 product.
    always_comb begin
        alu_result     = '0;
        alu_write_high = 1'b0;
        mul_a          = {{16{s0_q[15]}}, s0_q};
        mul_b          = {{16{s1_q[15]}}, s1_q};
        case (op_q)
            3'b000: alu_result = {16'h0000, s0_q + s1_q};
            3'b001: alu_result = {16'h0000, s0_q - s1_q};
            3'b010: begin
                alu_result     = mul_a * mul_b;
                alu_write_high = 1'b1;
            end
            3'b011: begin
                alu_result     = {16'h0000, s0_q} << s1_q;
                alu_write_high = 1'b1;
            end
            3'b100: alu_result = {16'h0000, s0_q ^ s1_q};
            3'b101: alu_result = {16'h0000, s0_q & s1_q};
            3'b110: alu_result = {16'h0000, s0_q | s1_q};
            default: alu_result = {16'h0000, ~s0_q};
        endcase
    end

    assign rd_hi = rd_q + {{(REG_ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wb_en      = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        done0      = 1'b0;
        done1      = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: state_next = WB_LO;
            WB_LO: begin
                wb_en   = 1'b1;
                wb_addr = rd_q;
                wb_data = lo_q;
                if (write_high_q) begin
                    state_next = WB_HI;
                end else begin
                    state_next = IDLE;
                    done0      = ~grant_id;
                    done1      = grant_id;
                end
            end
            WB_HI: begin
                wb_en      = 1'b1;
                wb_addr    = rd_hi;
                wb_data    = hi_q;
                done0      = ~grant_id;
                done1      = grant_id;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured on accept so requesters may change fields afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
            op_q         <= '0;
            s0_q         <= '0;
            s1_q         <= '0;
            rd_q         <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            write_high_q <= 1'b0;
        end else begin
            if (accept) begin
                grant_id   <= pick1;
                last_grant <= pick1;
                op_q       <= pick1 ? req1_op : req0_op;
                s0_q       <= pick1 ? req1_s0 : req0_s0;
                s1_q       <= pick1 ? req1_s1 : req0_s1;
                rd_q       <= pick1 ? req1_rd : req0_rd;
            end
            if (state == EXEC) begin
                lo_q         <= alu_result[15:0];
                hi_q         <= alu_result[31:16];
                write_high_q <= alu_write_high;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed and random operations checked
// cycle by cycle against a transaction-level ALU/arbitration model.
module tb_alu_arbiter;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [2:0]    req0_op, req1_op;
    logic [15:0]   req0_s0, req0_s1, req1_s0, req1_s1;
    logic [AW-1:0] req0_rd, req1_rd;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [15:0]   wb_data;
    logic          done0, done1, busy;
    logic [25:0]   obs;

    int checks = 0;
    int errors = 0;
    int model_last = 1;

    always #5 clk = ~clk;

    assign obs = {req0_ready, req1_ready, wb_en, wb_addr, wb_data, done0, done1, busy};

    alu_arbiter #(.REG_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_s0(req0_s0), .req0_s1(req0_s1), .req0_rd(req0_rd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_s0(req1_s0), .req1_s1(req1_s1), .req1_rd(req1_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .done0(done0), .done1(done1), .busy(busy)
    );

    // Returns {write_high, 32-bit result} from plain integer arithmetic.
    function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        longint r;
        logic   wh;
        wh = 1'b0;
        case (op)
            3'd0: r = (longint'(a) + longint'(b)) % 65536;
            3'd1: r = (longint'(a) - longint'(b) + 65536) % 65536;
            3'd2: begin r = longint'($signed(a)) * longint'($signed(b)); wh = 1'b1; end
            3'd3: begin r = (b >= 16'd32) ? 64'd0 : (longint'(a) << b); wh = 1'b1; end
            3'd4: r = longint'(a ^ b);
            3'd5: r = longint'(a & b);
            3'd6: r = longint'(a | b);
            default: r = 65535 - longint'(a);
        endcase
        return {wh, r[31:0]};
    endfunction

    task automatic drive_req(input int r, input logic v, input logic [2:0] op,
                             input logic [15:0] a, input logic [15:0] b, input logic [AW-1:0] rd);
        if (r == 0) begin
            req0_valid = v; req0_op = op; req0_s0 = a; req0_s1 = b; req0_rd = rd;
        end else begin
            req1_valid = v; req1_op = op; req1_s0 = a; req1_s1 = b; req1_rd = rd;
        end
    endtask

    task automatic test_reset;
        logic [25:0] e;
        rst_n = 1'b0;
        drive_req(0, 1'b1, 3'd2, 16'h1234, 16'h5678, 4'd3);
        drive_req(1, 1'b1, 3'd3, 16'h0F0F, 16'h0004, 4'd9);
        repeat (2) @(posedge clk);
        @(negedge clk);
        e = '0;
        checks++;
        if (obs !== e) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %h expected %h", obs, e);
        end
        @(posedge clk); #1;
        drive_req(0, 1'b0, 3'd0, 16'h0, 16'h0, 4'd0);
        drive_req(1, 1'b0, 3'd0, 16'h0, 16'h0, 4'd0);
        rst_n = 1'b1;
        model_last = 1;
        @(negedge clk);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h expected %h", obs, e);
        end
    endtask

    typedef struct {
        int            r;
        logic [2:0]    op;
        logic [15:0]   a;
        logic [15:0]   b;
        logic [AW-1:0] rd;
    } op_t;

    task automatic test_ops;
        op_t         list[$];
        op_t         t;
        logic [32:0] res;
        logic [25:0] e;
        int          hi_addr;
        list.push_back('{0, 3'd0, 16'd3, 16'd4, 4'd2});
        list.push_back('{1, 3'd2, 16'h0100, 16'h0100, 4'd5});
        list.push_back('{0, 3'd2, 16'hFFFE, 16'd3, 4'd15});
        list.push_back('{1, 3'd7, 16'h00FF, 16'h1234, 4'd3});
        for (int i = 0; i < 16; i++) begin
            t.r  = int'($urandom_range(0, 1));
            t.op = 3'($urandom_range(0, 7));
            t.a  = 16'($urandom);
            t.b  = (t.op == 3'd3) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            t.rd = AW'($urandom);
            list.push_back(t);
        end
        foreach (list[i]) begin
            t = list[i];
            res = ref_alu(t.op, t.a, t.b);
            hi_addr = (int'(t.rd) + 1) % (1 << AW);
            @(posedge clk); #1;
            drive_req(t.r, 1'b1, t.op, t.a, t.b, t.rd);
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) break;
            end
            checks++;
            if ({req0_ready, req1_ready} !== ((t.r == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("[TB] FAIL ops_accept[%0d]: got %b expected %b", i, {req0_ready, req1_ready},
                         (t.r == 0) ? 2'b10 : 2'b01);
            end
            model_last = t.r;
            @(posedge clk); #1;
            drive_req(t.r, 1'b0, 3'($urandom), 16'($urandom), 16'($urandom), AW'($urandom));
            @(negedge clk);
            e = {2'b00, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b1};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL ops_exec[%0d]: got %h expected %h", i, obs, e);
            end
            @(negedge clk);
            e = {2'b00, 1'b1, t.rd, res[15:0], (!res[32] && t.r == 0), (!res[32] && t.r == 1), 1'b1};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL ops_wb_lo[%0d]: got %h expected %h", i, obs, e);
            end
            if (res[32]) begin
                @(negedge clk);
                e = {2'b00, 1'b1, 4'(hi_addr), res[31:16], (t.r == 0), (t.r == 1), 1'b1};
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("[TB] FAIL ops_wb_hi[%0d]: got %h expected %h", i, obs, e);
                end
            end
            @(negedge clk);
            e = '0;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL ops_idle[%0d]: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_tie;
        logic [32:0] res;
        logic [25:0] e;
        int          grant;
        int          waited;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_last = 1;
        drive_req(0, 1'b1, 3'd1, 16'd5, 16'd7, 4'd1);
        drive_req(1, 1'b1, 3'd7, 16'h00FF, 16'hAAAA, 4'd3);
        for (int g = 0; g < 4; g++) begin
            grant = (model_last == 1) ? 0 : 1;
            waited = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) break;
                waited++;
            end
            checks++;
            if ({req0_ready, req1_ready, waited} !== {((grant == 0) ? 2'b10 : 2'b01), 32'd0}) begin
                errors++;
                $display("[TB] FAIL tie_grant[%0d]: got ready %b after %0d idle cycles, expected %b after 0",
                         g, {req0_ready, req1_ready}, waited, (grant == 0) ? 2'b10 : 2'b01);
            end
            model_last = grant;
            res = (grant == 0) ? ref_alu(3'd1, 16'd5, 16'd7) : ref_alu(3'd7, 16'h00FF, 16'hAAAA);
            @(negedge clk);
            @(negedge clk);
            e = {2'b00, 1'b1, (grant == 0) ? 4'd1 : 4'd3, res[15:0], (grant == 0), (grant == 1), 1'b1};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL tie_wb[%0d]: got %h expected %h", g, obs, e);
            end
        end
        @(posedge clk); #1;
        drive_req(0, 1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        drive_req(1, 1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        @(negedge clk);
        e = '0;
        checks++;
        if (obs !== e) begin
            errors++;
            $display("[TB] FAIL tie_idle: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_busy_hold;
        logic [32:0]   sh_res;
        logic [32:0]   add_res;
        logic [25:0]   e[$];
        logic [15:0]   a, b;
        logic [AW-1:0] rd;
        a  = 16'($urandom);
        b  = 16'($urandom);
        rd = AW'($urandom);
        sh_res  = ref_alu(3'd3, 16'h8001, 16'd4);
        add_res = ref_alu(3'd0, a, b);
        @(posedge clk); #1;
        drive_req(1, 1'b1, 3'd3, 16'h8001, 16'd4, 4'd7);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL hold_accept_sh: got %b expected 01", {req0_ready, req1_ready});
        end
        model_last = 1;
        @(posedge clk); #1;
        drive_req(1, 1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        drive_req(0, 1'b1, 3'd0, a, b, rd);
        e.push_back({2'b00, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b1});
        e.push_back({2'b00, 1'b1, 4'd7, sh_res[15:0], 1'b0, 1'b0, 1'b1});
        e.push_back({2'b00, 1'b1, 4'd8, sh_res[31:16], 1'b0, 1'b1, 1'b1});
        e.push_back({2'b10, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0});
        foreach (e[k]) begin
            @(negedge clk);
            checks++;
            if (obs !== e[k]) begin
                errors++;
                $display("[TB] FAIL hold_seq[%0d]: got %h expected %h", k, obs, e[k]);
            end
        end
        model_last = 0;
        @(posedge clk); #1;
        drive_req(0, 1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== {2'b00, 1'b1, rd, add_res[15:0], 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL hold_wb_add: got %h expected %h", obs,
                     {2'b00, 1'b1, rd, add_res[15:0], 1'b1, 1'b0, 1'b1});
        end
        @(negedge clk);
        checks++;
        if (obs !== 26'd0) begin
            errors++;
            $display("[TB] FAIL hold_idle: got %h expected %h", obs, 26'd0);
        end
    endtask

    task automatic test_reset_mid;
        logic [32:0]   mul_res;
        logic [32:0]   xor_res;
        logic [25:0]   e[$];
        logic [AW-1:0] rd;
        rd = AW'($urandom);
        mul_res = ref_alu(3'd2, 16'h1234, 16'h5678);
        xor_res = ref_alu(3'd4, 16'hF0F0, 16'h3C3C);
        @(posedge clk); #1;
        drive_req(1, 1'b1, 3'd2, 16'h1234, 16'h5678, rd);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rstmid_accept: got %b expected 01", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        drive_req(1, 1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== {2'b00, 1'b1, rd, mul_res[15:0], 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rstmid_wb_lo: got %h expected %h", obs,
                     {2'b00, 1'b1, rd, mul_res[15:0], 1'b0, 1'b0, 1'b1});
        end
        @(posedge clk); #1;
        drive_req(0, 1'b1, 3'd4, 16'hF0F0, 16'h3C3C, 4'd9);
        drive_req(1, 1'b1, 3'd5, 16'hFFFF, 16'h00FF, 4'd4);
        model_last = 1;
        e.push_back(26'd0);
        e.push_back({2'b10, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0});
        foreach (e[k]) begin
            @(negedge clk);
            checks++;
            if (obs !== e[k]) begin
                errors++;
                $display("[TB] FAIL rstmid_after[%0d]: got %h expected %h", k, obs, e[k]);
            end
            if (k == 0) begin
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        end
        model_last = 0;
        @(posedge clk); #1;
        drive_req(0, 1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        drive_req(1, 1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== {2'b00, 1'b1, 4'd9, xor_res[15:0], 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rstmid_wb_next: got %h expected %h", obs,
                     {2'b00, 1'b1, 4'd9, xor_res[15:0], 1'b1, 1'b0, 1'b1});
        end
        @(negedge clk);
        checks++;
        if (obs !== 26'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_idle: got %h expected %h", obs, 26'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive_req(0, 1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        drive_req(1, 1'b0, 3'd0, 16'd0, 16'd0, 4'd0);
        test_reset();
        test_ops();
        test_tie();
        test_busy_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one ALU instance between two requesters and sequences write-back of its results through a single register-file write port. Each requester issues an opcode, two 16-bit operands and a destination register index over a valid/ready handshake. A round-robin arbiter picks one request and registers the ALU result. A small FSM writes the low half to rd, and for MUL/SH also writes the high half to rd+1.

Parameters:
REG_ADDR_W, 4, register index width; register file holds 2^REG_ADDR_W entries.

Ports:
clk  in  1  clock; all state on rising edge.
rst_n  in  1  synchronous active-low reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle.
req0_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 MUL, 011 SH, 100 XOR, 101 AND, 110 OR, 111 NOT.
req0_s0  in  16  operand 0, signed.
req0_s1  in  16  operand 1, signed.
req0_rd  in  REG_ADDR_W  destination register index.
req1_valid, req1_ready, req1_op, req1_s0, req1_s1, req1_rd  same as requester 0.
wb_en  out  1  register-file write strobe.
wb_addr  out  REG_ADDR_W  write index.
wb_data  out  16  write data.
done0  out  1  one-cycle pulse when requester 0's operation completes.
done1  out  1  one-cycle pulse when requester 1's operation completes.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: while rst_n=0 at a rising edge, go to IDLE and drop any in-flight operation. Reset values:
  - req*_ready=0, wb_en=0, wb_addr=0, wb_data=0, done*=0, busy=0.
  - Internal registers cleared; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE -> EXEC -> WB_LO -> (WB_HI) -> IDLE.
- IDLE:
  - If any req*_valid is set, grant exactly one requester and drive its req*_ready=1 combinationally in this cycle.
  - Latch op/s0/s1/rd and the grant id, then go to EXEC.
  - req*_ready is 0 in every other state.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates on every grant.
- Requester rule: hold valid and all fields stable until ready. Dropping valid before ready is permitted and cancels the request.
- EXEC:
  - The internal ALU computes from the latched operands.
  - Register lo, hi and write_high at the end of the cycle, then go to WB_LO.
- ALU semantics:
  - ADD/SUB: 16-bit wrap.
  - MUL: signed 16x16 -> 32.
  - SH: {16'h0,s0} << s1, giving a 32-bit result.
  - XOR/AND/OR: bitwise on s0, s1.
  - NOT: ~s0.
  - write_high=1 only for MUL and SH.
- WB_LO:
  - wb_en=1, wb_addr=rd, wb_data=lo.
  - If write_high, go to WB_HI. Otherwise pulse done<id>=1 in this cycle and go to IDLE.
- WB_HI:
  - wb_en=1, wb_addr=rd+1 modulo 2^REG_ADDR_W (rd=all-ones wraps to 0), wb_data=hi.
  - Pulse done<id>=1 and go to IDLE.
- Latency from the accept cycle T:
  - Low write at T+2.
  - High write at T+3.
  - done in the last write cycle.
  - Next accept no earlier than T+3 (single-write ops) or T+4 (MUL/SH).
- Outputs:
  - wb_en, wb_addr, wb_data, done* and busy come directly from state/registers, with no combinational path from req inputs.
  - wb_addr/wb_data are 0 whenever wb_en=0.
- Request changes: a new valid arriving while busy waits; it is not lost as long as the requester holds it.
- Reset asserted in WB_LO, before a pending WB_HI: the WB_HI write must not occur and no done pulse is issued.

Test Plan:
- req0 ADD s0=3 s1=4 rd=2, accepted at T -> wb_en@T+2 addr=2 data=0x0007; done0@T+2; busy falls @T+3; no write @T+3.
- req1 MUL s0=0x0100 s1=0x0100 rd=5 -> @T+2 addr=5 data=0x0000; @T+3 addr=6 data=0x0001; done1@T+3 only.
- Signed MUL s0=-2 s1=3 rd=15 -> addr=15 data=0xFFFA, then wrap to addr=0 data=0xFFFF.
- Both valid continuously after reset: req0 SUB 5-7 rd=1, req1 NOT 0x00FF rd=3 ->
  - grants alternate 0,1,0,1.
  - first write addr=1 data=0xFFFE; second write addr=3 data=0xFF00.
  - each req ready pulses exactly once per grant.
- SH s0=0x8001 s1=4 rd=7 -> addr=7 data=0x0010, then addr=8 data=0x0008; req0_valid raised during busy is held and accepted in the first IDLE cycle.
- MUL accepted at T, rst_n=0 sampled @T+2 -> from T+3: all outputs 0, FSM in IDLE, no WB_HI write, no done pulse; after release, req0 is granted first on a tie.
